// File: rtl/dev_fetch_if.sv
// Byte-wide instruction memory read port: the fetch unit is the master, the memory is the slave.
interface dev_fetch_if #(
    parameter int ADDR_W = 16
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [7:0]        mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/dev_fetch.sv
// Instruction fetch unit: assembles a big-endian 32-bit word from four byte reads, issues it
// to the decoder with a one-cycle strobe, then picks the next fetch address from the control result.
module dev_fetch #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    dev_fetch_if.master       bus,
    output logic [31:0]       ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    output logic [ADDR_W-1:0] ret_addr,
    input  logic              exec_done,
    input  logic [1:0]        cu_op,
    input  logic [25:0]       jmp_offset,
    input  logic [ADDR_W-1:0] jmp_target,
    output logic              halted
);

    typedef enum logic [1:0] {
        FETCH,
        ISSUE,
        WAIT,
        HALT
    } state_t;

    localparam logic [1:0] OP_REL  = 2'd1;
    localparam logic [1:0] OP_ABS  = 2'd2;
    localparam logic [1:0] OP_HALT = 2'd3;

    state_t             state;
    state_t             state_next;
    logic [1:0]         byte_idx;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  next_pc;
    logic [ADDR_W+25:0] offset_ext;
    logic               last_ack;

    assign ret_addr   = ir_pc + ADDR_W'(4);
    assign offset_ext = {{ADDR_W{jmp_offset[25]}}, jmp_offset};
    assign last_ack   = (state == FETCH) && bus.mem_req && bus.mem_ack && (byte_idx == 2'd3);

    // Truncating the sign-extended offset before the add gives the same wrapped sum.
    always_comb begin
        next_pc = ret_addr;
        case (cu_op)
            OP_REL:  next_pc = ir_pc + offset_ext[ADDR_W-1:0];
            OP_ABS:  next_pc = {jmp_target[ADDR_W-1:2], 2'b00};
            default: next_pc = ret_addr;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH: if (last_ack) state_next = ISSUE;
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (exec_done) begin
                    state_next = (cu_op == OP_HALT) ? HALT : FETCH;
                end
            end
            HALT:    state_next = HALT;
            default: state_next = FETCH;
        endcase
    end

    // A request opens on the first FETCH cycle; each ack consumes one byte and advances the address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_idx     <= 2'd0;
            pc           <= RESET_PC;
            bus.mem_req  <= 1'b0;
            bus.mem_addr <= RESET_PC;
            ir           <= 32'h0;
            ir_pc        <= '0;
            ir_valid     <= 1'b0;
            halted       <= 1'b0;
        end else begin
            ir_valid <= 1'b0;
            case (state)
                FETCH: begin
                    if (!bus.mem_req) begin
                        bus.mem_req  <= 1'b1;
                        bus.mem_addr <= pc;
                        byte_idx     <= 2'd0;
                    end else if (bus.mem_ack) begin
                        case (byte_idx)
                            2'd0:    ir[31:24] <= bus.mem_rdata;
                            2'd1:    ir[23:16] <= bus.mem_rdata;
                            2'd2:    ir[15:8]  <= bus.mem_rdata;
                            default: ir[7:0]   <= bus.mem_rdata;
                        endcase
                        bus.mem_addr <= bus.mem_addr + ADDR_W'(1);
                        byte_idx     <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            bus.mem_req <= 1'b0;
                            ir_pc       <= pc;
                            ir_valid    <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (exec_done) begin
                        if (cu_op == OP_HALT) begin
                            halted <= 1'b1;
                        end else begin
                            pc <= next_pc;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dev_fetch.sv
// Directed bench for dev_fetch: a memory responder plus a transaction-level model checked every
// cycle on the falling edge, and literal expectations at the points the stimulus cares about.
module tb_dev_fetch;

    localparam int          ADDR_W   = 16;
    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk        = 1'b0;
    logic        rst        = 1'b1;
    logic        exec_done  = 1'b0;
    logic [1:0]  cu_op      = 2'd0;
    logic [25:0] jmp_offset = 26'd0;
    logic [15:0] jmp_target = 16'h0;
    logic [31:0] ir;
    logic [15:0] ir_pc;
    logic [15:0] ret_addr;
    logic        ir_valid;
    logic        halted;

    dev_fetch_if #(.ADDR_W(ADDR_W)) bus ();

    dev_fetch #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .ir         (ir),
        .ir_pc      (ir_pc),
        .ir_valid   (ir_valid),
        .ret_addr   (ret_addr),
        .exec_done  (exec_done),
        .cu_op      (cu_op),
        .jmp_offset (jmp_offset),
        .jmp_target (jmp_target),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] mem_image [int];
    int         stall_cfg [4];

    logic [15:0] exp_pc;
    logic [15:0] exp_ir_pc;
    logic [31:0] exp_ir;
    logic        exp_halted;
    logic        fetching;
    logic        issued;
    logic        issue_now;
    logic [15:0] exp_addr;
    logic [15:0] exp_ret;
    int          acks;
    int          age;
    int          fetch_age;
    int          stall_cnt;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [7:0] memByte(input logic [15:0] a);
        if (mem_image.exists(int'(a))) return mem_image[int'(a)];
        return a[7:0] * 8'd13 + a[15:8] + 8'h21;
    endfunction

    function automatic logic [31:0] expWord(input logic [15:0] a);
        return {memByte(a), memByte(a + 16'd1), memByte(a + 16'd2), memByte(a + 16'd3)};
    endfunction

    function automatic logic [15:0] nextPc(input logic [1:0] op, input logic [15:0] ipc,
                                           input logic [25:0] off, input logic [15:0] tgt);
        int o;
        o = off[25] ? int'(off) - (1 << 26) : int'(off);
        case (op)
            2'd1:    return 16'((int'(ipc) + o) & 32'hFFFF);
            2'd2:    return tgt & 16'hFFFC;
            default: return 16'((int'(ipc) + 4) & 32'hFFFF);
        endcase
    endfunction

    // Model and memory responder: check the last edge's results, then commit what the next edge consumes.
    always @(negedge clk) begin
        if (rst) begin
            checkOutput("rst_mem_req", bus.mem_req, 1'b0);
            checkOutput("rst_mem_addr", bus.mem_addr, RESET_PC);
            checkOutput("rst_ir", ir, 32'h0);
            checkOutput("rst_ir_pc", ir_pc, 16'h0);
            checkOutput("rst_ir_valid", ir_valid, 1'b0);
            checkOutput("rst_halted", halted, 1'b0);
            checkOutput("rst_ret_addr", ret_addr, 16'h0004);
            exp_pc        = RESET_PC;
            exp_ir_pc     = 16'h0;
            exp_ir        = 32'h0;
            exp_halted    = 1'b0;
            fetching      = 1'b1;
            issued        = 1'b0;
            acks          = 0;
            age           = 0;
            fetch_age     = 0;
            stall_cnt     = 0;
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = 8'h00;
        end else begin
            if (fetching) fetch_age++;
            issue_now = fetching && (acks == 4);
            checkOutput("ir_valid", ir_valid, issue_now);
            if (issue_now) begin
                exp_ir_pc = exp_pc;
                exp_ir    = expWord(exp_pc);
                fetching  = 1'b0;
                issued    = 1'b1;
                age       = 0;
            end
            exp_ret = exp_ir_pc + 16'd4;
            checkOutput("halted", halted, exp_halted);
            checkOutput("ir_pc", ir_pc, exp_ir_pc);
            checkOutput("ret_addr", ret_addr, exp_ret);
            if (!fetching) begin
                checkOutput("ir", ir, exp_ir);
                checkOutput("mem_req_idle", bus.mem_req, 1'b0);
            end else if (acks > 0 || fetch_age >= 2) begin
                checkOutput("mem_req_busy", bus.mem_req, 1'b1);
            end
            if (fetching && bus.mem_req) begin
                exp_addr = exp_pc + 16'(acks);
                checkOutput("mem_addr", bus.mem_addr, exp_addr);
            end

            if (issued) begin
                if (age >= 1 && exec_done) begin
                    issued = 1'b0;
                    if (cu_op == 2'd3) begin
                        exp_halted = 1'b1;
                    end else begin
                        exp_pc    = nextPc(cu_op, exp_ir_pc, jmp_offset, jmp_target);
                        fetching  = 1'b1;
                        acks      = 0;
                        fetch_age = 0;
                        stall_cnt = 0;
                    end
                end else begin
                    age++;
                end
            end

            bus.mem_ack = 1'b0;
            if (fetching && bus.mem_req && acks < 4) begin
                if (stall_cnt < stall_cfg[acks]) begin
                    stall_cnt++;
                end else begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = memByte(bus.mem_addr);
                    acks++;
                    stall_cnt = 0;
                end
            end
        end
    end

    task automatic applyStimulus(input logic [1:0] op, input logic [25:0] off, input logic [15:0] tgt);
        @(posedge clk);
        #2;
        exec_done  = 1'b1;
        cu_op      = op;
        jmp_offset = off;
        jmp_target = tgt;
        @(posedge clk);
        #2;
        exec_done = 1'b0;
    endtask

    task automatic waitIssue(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ir_valid && n < 100);
        if (!ir_valid) checkOutput("issue_timeout", ir_valid, 1'b1);
    endtask

    task automatic waitReq(input string name, input logic [15:0] addr);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.mem_req && n < 20);
        checkOutput({name, "_req"}, bus.mem_req, 1'b1);
        checkOutput(name, bus.mem_addr, addr);
    endtask

    initial begin
        int n;
        stall_cfg    = '{0, 0, 0, 0};
        mem_image[0] = 8'h10;
        mem_image[1] = 8'h00;
        mem_image[2] = 8'h00;
        mem_image[3] = 8'h2A;

        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        waitIssue(n);
        checkOutput("first_latency", n, 5);
        checkOutput("first_ir", ir, 32'h1000002A);
        checkOutput("first_ir_pc", ir_pc, 16'h0000);
        @(posedge clk);
        #1 checkOutput("valid_one_cycle", ir_valid, 1'b0);

        stall_cfg = '{0, 3, 0, 3};
        applyStimulus(2'd2, 26'd0, 16'h0000);
        waitIssue(n);
        checkOutput("stall_latency", n, 11);
        checkOutput("stall_ir", ir, 32'h1000002A);
        stall_cfg = '{0, 0, 0, 0};

        applyStimulus(2'd0, 26'd0, 16'h0);
        waitIssue(n);
        checkOutput("throughput_latency", n, 5);
        checkOutput("nop_ir_pc", ir_pc, 16'h0004);

        applyStimulus(2'd0, 26'd0, 16'h0);
        waitIssue(n);
        checkOutput("nop_ir_pc_8", ir_pc, 16'h0008);

        applyStimulus(2'd0, 26'd0, 16'h0);
        waitReq("nop_from_8", 16'h000C);
        waitIssue(n);

        applyStimulus(2'd2, 26'd0, 16'h000B);
        waitReq("abs_to_8", 16'h0008);
        waitIssue(n);

        applyStimulus(2'd1, 26'h3FFFFF8, 16'h0);
        waitReq("rel_minus8", 16'h0000);
        waitIssue(n);
        @(posedge clk);
        #1 checkOutput("ret_addr_wait", ret_addr, 16'h0004);

        applyStimulus(2'd2, 26'd0, 16'h0103);
        waitReq("abs_0103", 16'h0100);
        waitIssue(n);

        applyStimulus(2'd2, 26'd0, 16'hFFFE);
        waitReq("abs_fffe", 16'hFFFC);
        waitIssue(n);
        checkOutput("ret_addr_wrap", ret_addr, 16'h0000);

        applyStimulus(2'd0, 26'd0, 16'h0);
        waitReq("nop_wrap", 16'h0000);
        waitIssue(n);

        // A HALT presented while the word is still being issued must be ignored.
        exec_done = 1'b1;
        cu_op     = 2'd3;
        @(posedge clk);
        #2;
        exec_done = 1'b0;
        cu_op     = 2'd0;
        repeat (2) @(posedge clk);
        #1 checkOutput("halt_ignored_in_issue", halted, 1'b0);

        applyStimulus(2'd3, 26'd0, 16'h0);
        checkOutput("halted_set", halted, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #2;
            exec_done = i[0];
            cu_op     = 2'd0;
            #1 checkOutput("halt_mem_req", bus.mem_req, 1'b0);
        end
        exec_done = 1'b0;

        @(posedge clk);
        #2 rst = 1'b1;
        #1 checkOutput("rst_clears_halted", halted, 1'b0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        waitReq("restart_addr", RESET_PC);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checkOutput("async_mem_req", bus.mem_req, 1'b0);
        checkOutput("async_mem_addr", bus.mem_addr, RESET_PC);
        checkOutput("async_ir", ir, 32'h0);
        checkOutput("async_ir_valid", ir_valid, 1'b0);
        checkOutput("async_ir_pc", ir_pc, 16'h0);
        mem_image[0] = 8'hAB;
        mem_image[1] = 8'hCD;
        mem_image[2] = 8'hEF;
        mem_image[3] = 8'h01;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        waitIssue(n);
        checkOutput("restart_latency", n, 5);
        checkOutput("restart_ir", ir, 32'hABCDEF01);
        checkOutput("restart_ir_pc", ir_pc, 16'h0000);

        applyStimulus(2'd0, 26'd0, 16'h0);
        waitIssue(n);
        checkOutput("final_ir_pc", ir_pc, 16'h0004);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
